opb_register_simulink2ppc_latched: RTL and testbench

Read-back counterpart of the PPC-to-fabric software register: fabric logic presents a 32-bit word with a valid strobe, the block latches it, and the PowerPC reads it over the OPB bus. It is an OPB slave, single clock domain (fabric logic runs on `OPB_Clk`). It adds a sticky new-data flag and a saturating overrun counter, so software can detect missed samples.

---
 rtl/opb_s2p_pkg.sv | 8 +
 rtl/opb_register_simulink2ppc_latched_if.sv | 22 ++
 rtl/s2p_capture_regs.sv | 26 ++
 rtl/opb_register_simulink2ppc_latched.sv | 58 +++++
 tb/tb_opb_register_simulink2ppc_latched.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/opb_s2p_pkg.sv
// opb_s2p_pkg: register offsets, status bit layout and bus FSM states for the fabric-to-PPC read-back register
package opb_s2p_pkg;
  localparam logic [7:0] DATA_OFS = 8'h00;
  localparam logic [7:0] STAT_OFS = 8'h04;
  localparam int NEW_BIT = 31;
  localparam int OVR_W = 16;
  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;
endpackage

// File: rtl/opb_register_simulink2ppc_latched_if.sv
// opb_register_simulink2ppc_latched_if: OPB request (address, byte enables, write data, rnw, select, seqAddr) and slave reply (data, xferAck, errAck, retry, toutSup)
interface opb_register_simulink2ppc_latched_if;
  logic [0:31] OPB_ABus;
  logic [0:3] OPB_BE;
  logic [0:31] OPB_DBus;
  logic OPB_RNW;
  logic OPB_select;
  logic OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic Sl_xferAck;
  logic Sl_errAck;
  logic Sl_retry;
  logic Sl_toutSup;
  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
  modport slave (
    input OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/s2p_capture_regs.sv
// s2p_capture_regs: DATA/NEW/OVR latch; ports clk, rst_n, data_in, valid, rd_data_pulse, clr_ovr_pulse in; data, new_flag, ovr out
module s2p_capture_regs
  import opb_s2p_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      data_in,
  input  logic             valid,
  input  logic             rd_data_pulse,
  input  logic             clr_ovr_pulse,
  output logic [31:0]      data,
  output logic             new_flag,
  output logic [OVR_W-1:0] ovr
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data <= '0;
      new_flag <= 1'b0;
      ovr <= '0;
    end else begin
      if (valid) data <= data_in;
      new_flag <= valid || (new_flag && !rd_data_pulse);
      ovr <= clr_ovr_pulse ? '0 :
             (valid && new_flag && !rd_data_pulse && !(&ovr)) ? ovr + 1'b1 : ovr;
    end
endmodule

// File: rtl/opb_register_simulink2ppc_latched.sv
// opb_register_simulink2ppc_latched: OPB slave exposing latched fabric word (0x0) and NEW/OVR status (0x4); ports OPB_Clk, OPB_Rst_n, bus (slave), user_data_in, user_data_valid
module opb_register_simulink2ppc_latched
  import opb_s2p_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32
) (
  input logic                                 OPB_Clk,
  input logic                                 OPB_Rst_n,
  opb_register_simulink2ppc_latched_if.slave  bus,
  input logic [31:0]                          user_data_in,
  input logic                                 user_data_valid
);
  localparam int unused_widths = C_OPB_AWIDTH + C_OPB_DWIDTH;
  state_t state;
  logic [31:0] data;
  logic [31:0] status;
  logic new_flag;
  logic [OVR_W-1:0] ovr;
  logic hit, is_stat, start, rd_data_pulse, clr_ovr_pulse, unused_bits;
  assign hit = bus.OPB_select && bus.OPB_ABus >= C_BASEADDR && bus.OPB_ABus <= C_HIGHADDR;
  assign is_stat = bus.OPB_ABus[29] == STAT_OFS[2];
  assign start = state == IDLE && hit;
  assign rd_data_pulse = start && bus.OPB_RNW && !is_stat;
  assign clr_ovr_pulse = start && !bus.OPB_RNW && is_stat && |bus.OPB_BE;
  assign unused_bits = ^{bus.OPB_DBus, bus.OPB_seqAddr};
  assign bus.Sl_errAck = 1'b0;
  assign bus.Sl_retry = 1'b0;
  assign bus.Sl_toutSup = 1'b0;
  always_comb begin
    status = '0;
    status[NEW_BIT] = new_flag;
    status[OVR_W-1:0] = ovr;
  end
  s2p_capture_regs u_regs (
    .clk           (OPB_Clk),
    .rst_n         (OPB_Rst_n),
    .data_in       (user_data_in),
    .valid         (user_data_valid),
    .rd_data_pulse (rd_data_pulse),
    .clr_ovr_pulse (clr_ovr_pulse),
    .data          (data),
    .new_flag      (new_flag),
    .ovr           (ovr)
  );
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n)
    if (!OPB_Rst_n) begin
      state <= IDLE;
      bus.Sl_xferAck <= 1'b0;
      bus.Sl_DBus <= '0;
    end else begin
      state <= start ? ACK : state == ACK ? HOLD : IDLE;
      bus.Sl_xferAck <= start;
      bus.Sl_DBus <= (start && bus.OPB_RNW) ? (is_stat ? status : data) : '0;
    end
endmodule

// File: tb/tb_opb_register_simulink2ppc_latched.sv
// tb_opb_register_simulink2ppc_latched: directed and randomized checks of the read-back register against a transaction-level model
module tb_opb_register_simulink2ppc_latched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] din = '0;
  logic dv = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_data = '0;
  logic m_new = 1'b0;
  int m_ovr = 0;
  opb_register_simulink2ppc_latched_if bus_if ();
  opb_register_simulink2ppc_latched dut (
    .OPB_Clk         (clk),
    .OPB_Rst_n       (rst_n),
    .bus             (bus_if),
    .user_data_in    (din),
    .user_data_valid (dv)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask
  function automatic logic [31:0] stat();
    return {m_new, 15'b0, m_ovr[15:0]};
  endfunction
  task automatic m_cap(input logic v, input logic [31:0] w, input logic rdclr, input logic clr);
    logic was_new;
    was_new = m_new;
    if (rdclr) m_new = 1'b0;
    if (clr) m_ovr = 0;
    if (v) begin
      if (was_new && !rdclr && !clr) m_ovr = (m_ovr >= 65535) ? 65535 : m_ovr + 1;
      m_new = 1'b1;
      m_data = w;
    end
  endtask
  task automatic m_reset();
    m_data = '0;
    m_new = 1'b0;
    m_ovr = 0;
  endtask
  task automatic xfer(input string tag, input logic [31:0] a, input logic rnw, input logic [3:0] be,
                      input logic v, input logic [31:0] w);
    logic [31:0] want;
    logic st;
    @(negedge clk);
    bus_if.OPB_ABus = a;
    bus_if.OPB_RNW = rnw;
    bus_if.OPB_BE = be;
    bus_if.OPB_DBus = $urandom;
    bus_if.OPB_select = 1'b1;
    dv = v;
    din = w;
    st = a[2];
    want = st ? stat() : m_data;
    chk({tag, "_noack_at_select"}, {31'b0, bus_if.Sl_xferAck}, 32'd0);
    @(negedge clk);
    dv = 1'b0;
    bus_if.OPB_select = 1'b0;
    chk({tag, "_ack"}, {31'b0, bus_if.Sl_xferAck}, 32'd1);
    if (rnw) chk({tag, "_rdata"}, bus_if.Sl_DBus, want);
    m_cap(v, w, rnw && !st, !rnw && st && |be);
    @(negedge clk);
    chk({tag, "_ack_drop"}, bus_if.Sl_DBus | {31'b0, bus_if.Sl_xferAck}, 32'd0);
  endtask
  task automatic cap(input logic [31:0] w);
    @(negedge clk);
    dv = 1'b1;
    din = w;
    @(negedge clk);
    dv = 1'b0;
    m_cap(1'b1, w, 1'b0, 1'b0);
  endtask
  initial begin
    int acks, adj;
    logic prev;
    bus_if.OPB_ABus = '0;
    bus_if.OPB_BE = '0;
    bus_if.OPB_DBus = '0;
    bus_if.OPB_RNW = 1'b1;
    bus_if.OPB_select = 1'b0;
    bus_if.OPB_seqAddr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", bus_if.Sl_DBus | {28'b0, bus_if.Sl_xferAck, bus_if.Sl_errAck, bus_if.Sl_retry, bus_if.Sl_toutSup}, 32'd0);
    rst_n = 1'b1;
    xfer("reset_status", 32'h4, 1'b1, 4'h0, 1'b0, '0);
    // capture one cycle before the read decode: word must already be visible
    dv = 1'b1;
    din = 32'hDEADBEEF;
    m_cap(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    xfer("rd_deadbeef", 32'h0, 1'b1, 4'h0, 1'b0, '0);
    xfer("stat_after_rd", 32'h4, 1'b1, 4'h0, 1'b0, '0);
    cap(32'd1);
    cap(32'd2);
    xfer("stat_two_caps", 32'h4, 1'b1, 4'h0, 1'b0, '0);
    xfer("rd_two", 32'h0, 1'b1, 4'h0, 1'b0, '0);
    xfer("stat_ovr1", 32'h4, 1'b1, 4'h0, 1'b0, '0);
    cap(32'h11);
    xfer("rd_coincident", 32'h0, 1'b1, 4'h0, 1'b1, 32'h55);
    xfer("stat_coincident", 32'h4, 1'b1, 4'h0, 1'b0, '0);
    xfer("rd_after_coinc", 32'h0, 1'b1, 4'h0, 1'b0, '0);
    cap(32'h66);
    cap(32'h77);
    xfer("wr_be0", 32'h4, 1'b0, 4'h0, 1'b0, '0);
    xfer("stat_be0", 32'h4, 1'b1, 4'h0, 1'b0, '0);
    xfer("wr_clr_overrun", 32'h4, 1'b0, 4'h2, 1'b1, 32'h88);
    xfer("stat_clr_wins", 32'h4, 1'b1, 4'h0, 1'b0, '0);
    xfer("wr_data_ignored", 32'h0, 1'b0, 4'hF, 1'b0, '0);
    xfer("rd_data_kept", 32'h0, 1'b1, 4'h0, 1'b0, '0);
    @(negedge clk);
    bus_if.OPB_ABus = 32'h4;
    bus_if.OPB_RNW = 1'b1;
    bus_if.OPB_select = 1'b1;
    acks = 0;
    adj = 0;
    prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_if.Sl_xferAck && prev) adj++;
      if (bus_if.Sl_xferAck) acks++;
      prev = bus_if.Sl_xferAck;
    end
    bus_if.OPB_select = 1'b0;
    chk("held_select_acks", acks, 32'd2);
    chk("held_select_adjacent", adj, 32'd0);
    repeat (3) @(negedge clk);
    bus_if.OPB_ABus = 32'h100;
    bus_if.OPB_select = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("oow_high", bus_if.Sl_DBus | {31'b0, bus_if.Sl_xferAck}, 32'd0);
    end
    bus_if.OPB_ABus = 32'hFFFF_FF04;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("oow_far", bus_if.Sl_DBus | {31'b0, bus_if.Sl_xferAck}, 32'd0);
    end
    bus_if.OPB_select = 1'b0;
    for (int i = 0; i < 60; i++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 5);
      a = $urandom_range(0, 255) & 32'hFB;
      case (op)
        0: cap($urandom);
        1: xfer("rnd_rd_data", a, 1'b1, 4'($urandom), 1'b0, '0);
        2: xfer("rnd_rd_stat", a | 32'h4, 1'b1, 4'($urandom), 1'b0, '0);
        3: xfer("rnd_wr_stat", a | 32'h4, 1'b0, 4'($urandom), 1'($urandom), $urandom);
        4: xfer("rnd_rd_coinc", a, 1'b1, 4'h0, 1'b1, $urandom);
        default: xfer("rnd_wr_data", a, 1'b0, 4'($urandom), 1'($urandom), $urandom);
      endcase
    end
    xfer("rnd_final_stat", 32'h4, 1'b1, 4'h0, 1'b0, '0);
    @(negedge clk);
    dv = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      din = i;
      @(negedge clk);
      m_cap(1'b1, i, 1'b0, 1'b0);
    end
    dv = 1'b0;
    xfer("stat_saturated", 32'h4, 1'b1, 4'h0, 1'b0, '0);
    xfer("wr_clr_sat", 32'h4, 1'b0, 4'hF, 1'b0, '0);
    xfer("stat_after_clr", 32'h4, 1'b1, 4'h0, 1'b0, '0);
    cap(32'hCAFE_F00D);
    @(negedge clk);
    bus_if.OPB_ABus = 32'h0;
    bus_if.OPB_RNW = 1'b1;
    bus_if.OPB_select = 1'b1;
    @(negedge clk);
    chk("pre_reset_ack_data", bus_if.Sl_DBus, 32'hCAFE_F00D);
    rst_n = 1'b0;
    #1;
    chk("async_reset_ack", {31'b0, bus_if.Sl_xferAck}, 32'd0);
    chk("async_reset_dbus", bus_if.Sl_DBus, 32'd0);
    bus_if.OPB_select = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_ack_after_release", bus_if.Sl_DBus | {31'b0, bus_if.Sl_xferAck}, 32'd0);
    end
    xfer("post_reset_data", 32'h0, 1'b1, 4'h0, 1'b0, '0);
    xfer("post_reset_stat", 32'h4, 1'b1, 4'h0, 1'b0, '0);
    cap(32'h1234_5678);
    xfer("first_cap_no_ovr", 32'h4, 1'b1, 4'h0, 1'b0, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
